// File: rtl/common.sv
// Shared bus types for the core's ibus/dbus ports and the cache/memory bus.
package common;

  typedef logic [63:0] addr_t;
  typedef logic [63:0] word_t;
  typedef logic [7:0]  strobe_t;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef enum logic [7:0] {
    MLEN1  = 8'd0,
    MLEN2  = 8'd1,
    MLEN4  = 8'd3,
    MLEN8  = 8'd7,
    MLEN16 = 8'd15
  } mlen_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'd0,
    AXI_BURST_INCR  = 2'd1,
    AXI_BURST_WRAP  = 2'd2
  } axi_burst_type_t;

  typedef struct packed {
    logic  valid;
    addr_t addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic    valid;
    addr_t   addr;
    msize_t  size;
    strobe_t strobe;
    word_t   data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  typedef struct packed {
    logic            valid;
    logic            is_write;
    msize_t          size;
    addr_t           addr;
    strobe_t         strobe;
    word_t           data;
    mlen_t           len;
    axi_burst_type_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic  ready;
    logic  last;
    word_t data;
  } cbus_resp_t;

endpackage

// File: rtl/core_bus_arbiter_pkg.sv
// Arbiter-local FSM state and grant-owner encodings.
package core_bus_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/bus_req_convert.sv
// Combinational translation of a dbus-shaped request into a single-beat cbus request.
module bus_req_convert
  import common::*;
(
  input  dbus_req_t req,
  output cbus_req_t creq
);

  always_comb begin
    creq          = '0;
    creq.valid    = req.valid;
    creq.is_write = |req.strobe;
    creq.size     = req.size;
    creq.addr     = req.addr;
    creq.strobe   = req.strobe;
    creq.data     = req.data;
    creq.len      = MLEN1;
    creq.burst    = AXI_BURST_FIXED;
  end

endmodule

// File: rtl/core_bus_arbiter.sv
// Latched one-transaction-at-a-time arbiter of ibus/dbus onto cbus.
// Define CORE_BUS_ARB_RR_EN for round-robin; default is fixed dbus-over-ibus priority.
module core_bus_arbiter
  import common::*;
  import core_bus_arbiter_pkg::*;
#(
  parameter int unsigned AWIDTH = 64,
  parameter int unsigned DWIDTH = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp
);

  state_t    state;
  owner_t    owner;
  cbus_req_t saved_req;
  dbus_req_t ireq_as_d;
  cbus_req_t icreq;
  cbus_req_t dcreq;
  logic      pick_d;
  logic      done;

  // A fetch is a 4-byte read with no strobes, so it reuses the dbus translation.
  always_comb begin
    ireq_as_d       = '0;
    ireq_as_d.valid = ireq.valid;
    ireq_as_d.addr  = ireq.addr;
    ireq_as_d.size  = MSIZE4;
  end

  bus_req_convert u_conv_i (.req(ireq_as_d), .creq(icreq));
  bus_req_convert u_conv_d (.req(dreq),      .creq(dcreq));

`ifdef CORE_BUS_ARB_RR_EN
  owner_t last_grant;

  always_comb pick_d = dreq.valid && !(ireq.valid && last_grant == OWN_D);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_grant <= OWN_I;
    else if (state == IDLE && (ireq.valid || dreq.valid))
      last_grant <= pick_d ? OWN_D : OWN_I;
  end
`else
  always_comb pick_d = dreq.valid;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= OWN_I;
      saved_req <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ireq.valid || dreq.valid) begin
            saved_req <= pick_d ? dcreq : icreq;
            owner     <= pick_d ? OWN_D : OWN_I;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cresp.ready && cresp.last)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    creq = '0;
    if (state == BUSY) begin
      creq       = saved_req;
      creq.valid = 1'b1;
      creq.addr  = addr_t'(saved_req.addr[AWIDTH-1:0]);
    end
  end

  // Responses are gated by the grant so the non-owner port never sees a pulse.
  always_comb begin
    done  = (state == BUSY) && cresp.ready && cresp.last;
    iresp = '0;
    dresp = '0;
    if (done && owner == OWN_I) begin
      iresp.addr_ok = 1'b1;
      iresp.data_ok = 1'b1;
      iresp.data    = saved_req.addr[2] ? cresp.data[63:32] : cresp.data[31:0];
    end
    if (done && owner == OWN_D) begin
      dresp.addr_ok = 1'b1;
      dresp.data_ok = 1'b1;
      dresp.data    = word_t'(cresp.data[DWIDTH-1:0]);
    end
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed self-checking bench for core_bus_arbiter (default or round-robin build).
module tb_core_bus_arbiter;
  import common::*;
  import core_bus_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  int unsigned errors = 0;
  int unsigned checks = 0;

  localparam logic [63:0] IADDR = 64'h8000_0000;
  localparam logic [63:0] DADDR = 64'h8000_2000;
  localparam logic [63:0] RDATA = 64'h1111_2222_3333_4444;

  core_bus_arbiter #(.AWIDTH(64), .DWIDTH(64)) dut (
    .clk   (clk),
    .rst   (rst),
    .ireq  (ireq),
    .iresp (iresp),
    .dreq  (dreq),
    .dresp (dresp),
    .creq  (creq),
    .cresp (cresp)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Both ports request in the same IDLE cycle; winner completes, loser follows after one bubble.
  task automatic contend(input string tag, input bit d_first);
    ireq.valid  = 1'b1;
    ireq.addr   = IADDR;
    dreq.valid  = 1'b1;
    dreq.addr   = DADDR;
    dreq.strobe = '0;
    dreq.size   = MSIZE8;
    dreq.data   = '0;
    tick();
    chk({tag, "_win_valid"}, creq.valid, 1'b1);
    chk({tag, "_win_addr"}, creq.addr, d_first ? DADDR : IADDR);
    cresp.ready = 1'b1;
    cresp.last  = 1'b1;
    cresp.data  = RDATA;
    #1;
    chk({tag, "_win_ok"}, d_first ? dresp.data_ok : iresp.data_ok, 1'b1);
    chk({tag, "_lose_quiet"}, d_first ? iresp.data_ok : dresp.data_ok, 1'b0);
    if (d_first) dreq.valid = 1'b0;
    else         ireq.valid = 1'b0;
    tick();
    chk({tag, "_bubble"}, creq.valid, 1'b0);
    cresp = '0;
    tick();
    chk({tag, "_lose_valid"}, creq.valid, 1'b1);
    chk({tag, "_lose_addr"}, creq.addr, d_first ? IADDR : DADDR);
    cresp.ready = 1'b1;
    cresp.last  = 1'b1;
    cresp.data  = RDATA;
    #1;
    chk({tag, "_lose_ok"}, d_first ? iresp.data_ok : dresp.data_ok, 1'b1);
    chk({tag, "_lose_data"}, d_first ? {32'h0, iresp.data} : dresp.data,
        d_first ? 64'h3333_4444 : RDATA);
    ireq.valid = 1'b0;
    dreq.valid = 1'b0;
    tick();
    cresp = '0;
  endtask

  initial begin
    rst   = 1'b1;
    ireq  = '0;
    dreq  = '0;
    cresp = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_creq", |creq, 1'b0);
    chk("rst_iresp", |iresp, 1'b0);
    chk("rst_dresp", |dresp, 1'b0);
    chk("rst_state", dut.state, IDLE);
    chk("rst_owner", dut.owner, OWN_I);
    rst = 1'b0;

    // Single fetch, odd word, with a non-last ready beat on the way
    ireq.valid = 1'b1;
    ireq.addr  = 64'h8000_0004;
    #1;
    chk("fetch_c0_valid", creq.valid, 1'b0);
    tick();
    chk("fetch_c1_valid", creq.valid, 1'b1);
    chk("fetch_c1_addr", creq.addr, 64'h8000_0004);
    chk("fetch_c1_wr", creq.is_write, 1'b0);
    chk("fetch_c1_size", creq.size, MSIZE4);
    chk("fetch_c1_len", creq.len, MLEN1);
    ireq.valid  = 1'b0;
    ireq.addr   = 64'h8000_0FF0;
    cresp.ready = 1'b1;
    cresp.last  = 1'b0;
    cresp.data  = 64'hAAAA_BBBB_CCCC_DDDD;
    #1;
    chk("fetch_nolast_ok", iresp.data_ok, 1'b0);
    tick();
    chk("fetch_stable_valid", creq.valid, 1'b1);
    chk("fetch_stable_addr", creq.addr, 64'h8000_0004);
    cresp = '0;
    tick();
    cresp.ready = 1'b1;
    cresp.last  = 1'b1;
    cresp.data  = RDATA;
    #1;
    chk("fetch_data_ok", iresp.data_ok, 1'b1);
    chk("fetch_addr_ok", iresp.addr_ok, 1'b1);
    chk("fetch_data", iresp.data, 32'h1111_2222);
    chk("fetch_dresp_zero", |dresp, 1'b0);
    tick();
    chk("fetch_pulse_end", iresp.data_ok, 1'b0);
    chk("fetch_idle_valid", creq.valid, 1'b0);
    cresp = '0;

    // Store with live request changing under it
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h8000_1000;
    dreq.strobe = 8'h0F;
    dreq.size   = MSIZE4;
    dreq.data   = 64'hDEAD_BEEF;
    tick();
    chk("store_valid", creq.valid, 1'b1);
    chk("store_wr", creq.is_write, 1'b1);
    chk("store_strobe", creq.strobe, 8'h0F);
    chk("store_addr", creq.addr, 64'h8000_1000);
    chk("store_data", creq.data, 64'hDEAD_BEEF);
    dreq = '0;
    dreq.strobe = 8'hFF;
    tick();
    chk("store_hold_strobe", creq.strobe, 8'h0F);
    chk("store_hold_data", creq.data, 64'hDEAD_BEEF);
    cresp.ready = 1'b1;
    cresp.last  = 1'b1;
    cresp.data  = 64'h0123_4567_89AB_CDEF;
    #1;
    chk("store_data_ok", dresp.data_ok, 1'b1);
    chk("store_rdata", dresp.data, 64'h0123_4567_89AB_CDEF);
    chk("store_iresp_zero", |iresp, 1'b0);
    tick();
    chk("store_pulse_end", dresp.data_ok, 1'b0);
    cresp = '0;
    dreq  = '0;

`ifdef CORE_BUS_ARB_RR_EN
    contend("cont1", 1'b0);
    contend("cont2", 1'b0);
`else
    contend("cont1", 1'b1);
    contend("cont2", 1'b1);
`endif

    // Reset in the middle of a transaction
    dreq.valid = 1'b1;
    dreq.addr  = 64'h8000_3000;
    tick();
    chk("rstmid_busy", creq.valid, 1'b1);
    dreq.valid  = 1'b0;
    cresp.ready = 1'b1;
    cresp.last  = 1'b0;
    cresp.data  = RDATA;
    #1;
    rst = 1'b1;
    #1;
    chk("rstmid_valid", creq.valid, 1'b0);
    chk("rstmid_creq", |creq, 1'b0);
    cresp.last = 1'b1;
    #1;
    chk("rstmid_dresp", |dresp, 1'b0);
    chk("rstmid_iresp", |iresp, 1'b0);
    tick();
    rst   = 1'b0;
    cresp = '0;
    #1;
    chk("rstmid_state", dut.state, IDLE);
    tick();
    chk("rstmid_after", creq.valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
